// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS boot program loader: FSM states,
// frame start byte and the byte offsets of the frame header fields.
package mips_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_ADDR_H = 4'd1,
      ST_ADDR_L = 4'd2,
      ST_CNT_H  = 4'd3,
      ST_CNT_L  = 4'd4,
      ST_DATA   = 4'd5,
      ST_CSUM   = 4'd6,
      ST_DONE   = 4'd7,
      ST_ERROR  = 4'd8
   } state_t;

   localparam logic [7:0] MAGIC_BYTE = 8'hA5;

   // Byte offsets of the header fields within a frame
   localparam int OFS_MAGIC  = 0;
   localparam int OFS_BASE_H = 1;
   localparam int OFS_BASE_L = 2;
   localparam int OFS_CNT_H  = 3;
   localparam int OFS_CNT_L  = 4;
   localparam int OFS_DATA   = 5;

endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-stream input and core-memory write bus of the program loader.
// The master modport is the loader side; slave is the environment side.
interface mips_prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic              s_valid;
   logic              s_ready;
   logic [7:0]        s_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      input  s_valid,
      input  s_data,
      output s_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      output s_valid,
      output s_data,
      input  s_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/mips_prog_loader.sv
// Boot-time program loader: parses framed bytes, packs big-endian words,
// writes them into core memory and releases the core with a start PC.
module mips_prog_loader
   import mips_loader_pkg::*;
#(
   parameter int         ADDR_W = 10,
   parameter logic [7:0] MAGIC  = MAGIC_BYTE
) (
   input  logic                clk1,
   input  logic                rst_n,
   mips_prog_loader_if.master  bus,
   output logic                cpu_run,
   output logic [31:0]         start_pc,
   output logic                busy,
   output logic                err
);

   state_t            state, state_nx;
   logic [7:0]        csum;
   logic [1:0]        byte_idx;
   logic [15:0]       word_idx;
   logic [ADDR_W-1:0] base_q;
   logic [15:0]       cnt_q;
   logic [23:0]       asm_q;
   logic              accept;
   logic              frame_start;
   logic              word_done;
   logic              last_word;

   // Memory always accepts a write, so the stream is never throttled
   assign bus.s_ready = 1'b1;

   // Next-state decode and per-byte qualifiers
   always_comb begin
      state_nx    = state;
      accept      = bus.s_valid & bus.s_ready;
      frame_start = 1'b0;
      word_done   = accept && (state == ST_DATA) && (byte_idx == 2'd3);
      last_word   = ((word_idx + 16'd1) == cnt_q);
      busy        = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (accept && bus.s_data == MAGIC) begin
               frame_start = 1'b1;
               state_nx    = ST_ADDR_H;
            end
         end
         ST_ADDR_H: begin
            busy = 1'b1;
            if (accept) state_nx = ST_ADDR_L;
         end
         ST_ADDR_L: begin
            busy = 1'b1;
            if (accept) state_nx = ST_CNT_H;
         end
         ST_CNT_H: begin
            busy = 1'b1;
            if (accept) state_nx = ST_CNT_L;
         end
         ST_CNT_L: begin
            busy = 1'b1;
            if (accept)
               state_nx = ({cnt_q[15:8], bus.s_data} == 16'd0) ? ST_CSUM : ST_DATA;
         end
         ST_DATA: begin
            busy = 1'b1;
            if (word_done && last_word) state_nx = ST_CSUM;
         end
         ST_CSUM: begin
            busy = 1'b1;
            if (accept) state_nx = (bus.s_data == csum) ? ST_DONE : ST_ERROR;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Control state, checksum, write strobe and core release
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         csum          <= 8'h00;
         byte_idx      <= 2'd0;
         word_idx      <= 16'd0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'h0;
         cpu_run       <= 1'b0;
         start_pc      <= 32'h0;
         err           <= 1'b0;
      end else begin
         state      <= state_nx;
         bus.mem_we <= 1'b0;
         if (frame_start) begin
            csum     <= 8'h00;
            err      <= 1'b0;
            cpu_run  <= 1'b0;
            byte_idx <= 2'd0;
            word_idx <= 16'd0;
         end
         if (accept) begin
            case (state)
               ST_ADDR_H, ST_ADDR_L, ST_CNT_H, ST_CNT_L:
                  csum <= csum ^ bus.s_data;
               ST_DATA: begin
                  csum     <= csum ^ bus.s_data;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= base_q + ADDR_W'(word_idx);
                     bus.mem_wdata <= {asm_q, bus.s_data};
                     word_idx      <= word_idx + 16'd1;
                  end
               end
               ST_CSUM: begin
                  if (bus.s_data == csum) begin
                     cpu_run  <= 1'b1;
                     start_pc <= 32'(base_q);
                  end else begin
                     err     <= 1'b1;
                     cpu_run <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Header fields and word assembly; always rewritten before use
   always_ff @(posedge clk1) begin
      if (accept) begin
         case (state)
            ST_ADDR_H: base_q       <= ADDR_W'({bus.s_data, 8'h00});
            ST_ADDR_L: base_q       <= base_q | ADDR_W'(bus.s_data);
            ST_CNT_H:  cnt_q[15:8]  <= bus.s_data;
            ST_CNT_L:  cnt_q[7:0]   <= bus.s_data;
            ST_DATA:   asm_q        <= {asm_q[15:0], bus.s_data};
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for the MIPS program loader: expected memory writes
// are queued as frames are sent and popped by an independent monitor.
module tb_mips_prog_loader;
   import mips_loader_pkg::*;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;

   logic clk1;
   logic rst_n;
   logic cpu_run;
   logic [31:0] start_pc;
   logic busy;
   logic err;

   int checks;
   int errors;
   wr_t exp_q[$];

   mips_prog_loader_if #(.ADDR_W(10)) bus ();

   mips_prog_loader #(.ADDR_W(10), .MAGIC(8'hA5)) dut (
      .clk1     (clk1),
      .rst_n    (rst_n),
      .bus      (bus.master),
      .cpu_run  (cpu_run),
      .start_pc (start_pc),
      .busy     (busy),
      .err      (err)
   );

   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the scoreboard
   always @(negedge clk1) begin
      if (bus.mem_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bus.mem_addr !== e.a || bus.mem_wdata !== e.d) begin
               errors++;
               $display("FAIL mem_write: got addr %h data %h expected addr %h data %h",
                        bus.mem_addr, bus.mem_wdata, e.a, e.d);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk1);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      @(posedge clk1);
      #1;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
   endtask

   task automatic send_frame(input bq_t f, input int gap_max);
      foreach (f[i]) begin
         if (gap_max > 0) idle($urandom_range(0, gap_max));
         send_byte(f[i]);
      end
   endtask

   task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic chk_status(input string tag, input logic run, input logic er,
                             input logic [31:0] pc);
      idle(2);
      chk({tag, "_cpu_run"}, 32'(cpu_run), 32'(run));
      chk({tag, "_err"}, 32'(err), 32'(er));
      if (run) chk({tag, "_start_pc"}, start_pc, pc);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t good, bad, empty, wrap, part;
      checks = 0;
      errors = 0;
      good  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h78,
                8'hFC, 8'h00, 8'h00, 8'h00, 8'hAF};
      bad   = good;
      bad[13] = 8'hAE;
      empty = '{8'hA5, 8'h00, 8'h78, 8'h00, 8'h00, 8'h78};
      wrap  = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h00, 8'h00, 8'h02, 8'hFD};
      part  = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h78,
                8'hFC, 8'h00};

      // Reset values
      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      #1;
      chk("rst_s_ready", 32'(bus.s_ready), 32'h1);
      chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
      chk("rst_cpu_run", 32'(cpu_run), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_start_pc", start_pc, 32'h0);
      #11;
      rst_n = 1'b1;
      idle(1);

      // 1: good load
      push_wr(10'h000, 32'h28010078);
      push_wr(10'h001, 32'hFC000000);
      send_frame(good, 0);
      chk_status("t1", 1'b1, 1'b0, 32'h0);

      // 2: bad checksum, then recovery
      push_wr(10'h000, 32'h28010078);
      push_wr(10'h001, 32'hFC000000);
      send_frame(bad, 0);
      chk_status("t2", 1'b0, 1'b1, 32'h0);
      chk("t2_state", 32'(dut.state), 32'(ST_ERROR));
      push_wr(10'h000, 32'h28010078);
      push_wr(10'h001, 32'hFC000000);
      send_frame(good, 0);
      chk_status("t2r", 1'b1, 1'b0, 32'h0);

      // 3: empty frame
      send_frame(empty, 0);
      chk_status("t3", 1'b1, 1'b0, 32'h78);

      // 4: address wrap
      push_wr(10'h3FF, 32'h00000001);
      push_wr(10'h000, 32'h00000002);
      send_frame(wrap, 0);
      chk_status("t4", 1'b1, 1'b0, 32'h3FF);

      // 5: junk then gapped good frame
      send_frame('{8'h11, 8'h22}, 5);
      chk("t5_junk_busy", 32'(busy), 32'h0);
      push_wr(10'h000, 32'h28010078);
      push_wr(10'h001, 32'hFC000000);
      send_frame(good, 5);
      chk_status("t5", 1'b1, 1'b0, 32'h0);

      // 6: reset in the middle of the data phase
      push_wr(10'h000, 32'h28010078);
      send_frame(part, 0);
      chk("t6_busy_before", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_cpu_run", 32'(cpu_run), 32'h0);
      chk("t6_rst_mem_we", 32'(bus.mem_we), 32'h0);
      chk("t6_rst_mem_wdata", bus.mem_wdata, 32'h0);
      idle(3);
      rst_n = 1'b1;
      idle(3);
      chk("t6_no_write", 32'(exp_q.size()), 32'h0);
      push_wr(10'h000, 32'h28010078);
      push_wr(10'h001, 32'hFC000000);
      send_frame(good, 0);
      chk_status("t6r", 1'b1, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
